// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the CCFF chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    localparam logic [7:0] CCFF_MARKER     = 8'hA5;
    localparam int         CCFF_MARKER_LEN = 8;

    function automatic int words_per_load(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream (valid/ready) between bitstream source and loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Word buffer feeding one bit per cycle; fetches exactly ceil(CHAIN_LEN/WORD_W) words
// per load and can bypass the incoming word so back-to-back words have no bubble.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 want,
    ccff_chain_loader_if.slave   word_if,
    output logic                 avail,
    output logic                 bit_o
);
    localparam int WORDS = words_per_load(CHAIN_LEN, WORD_W);
    localparam int RW    = $clog2(WORD_W + 1);
    localparam int CW    = $clog2(WORDS + 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              empty, last, more, xfer, take;

    assign empty = (rem_q == '0);
    assign last  = (rem_q == RW'(1));
    assign more  = (wcnt_q < CW'(WORDS));
    // want implies the last buffered bit is consumed this cycle, so a refill never overruns
    assign word_if.word_ready = want && more && (empty || last);
    assign xfer  = word_if.word_ready && word_if.word_valid;
    assign avail = !empty || xfer;
    assign take  = want && avail;
    assign bit_o = empty ? word_if.word_data[0] : buf_q[0];

    always_comb begin
        buf_d  = buf_q;
        rem_d  = rem_q;
        wcnt_d = wcnt_q;
        if (flush) begin
            rem_d  = '0;
            wcnt_d = '0;
        end else begin
            if (take && !empty) begin
                buf_d = buf_q >> 1;
                rem_d = rem_q - RW'(1);
            end
            if (xfer) begin
                wcnt_d = wcnt_q + CW'(1);
                if (empty) begin
                    buf_d = word_if.word_data >> 1;
                    rem_d = RW'(WORD_W - 1);
                end else begin
                    buf_d = word_if.word_data;
                    rem_d = RW'(WORD_W);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            rem_q  <= '0;
            wcnt_q <= '0;
        end else begin
            buf_q  <= buf_d;
            rem_q  <= rem_d;
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes configuration words LSB first onto a CCFF chain head, gating the chain with
// config_enable. Define CCFF_LOADER_CHAIN_CHECK_EN for the marker preamble and tail check.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic                prog_clock,
    input  logic                prog_reset_n,
    input  logic                start,
    input  logic                ccff_tail,
    ccff_chain_loader_if.slave  word_if,
    output logic                ccff_head,
    output logic                config_enable,
    output logic                busy,
    output logic                done,
    output logic                chain_err
);
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    localparam int PRE = CCFF_MARKER_LEN;
`else
    localparam int PRE = 0;
`endif
    localparam logic [31:0] TOTAL = 32'(CHAIN_LEN + PRE);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        head_q, head_d;
    logic        cen_q, cen_d;
    logic        done_q, done_d;
    logic        flush, want, ser_avail, ser_bit;

    assign flush = (state_q == ST_IDLE) && start;
    assign want  = (state_q == ST_LOAD) && (cnt_q != TOTAL);

    ccff_word_serializer #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) u_ser (
        .clk     (prog_clock),
        .rst_n   (prog_reset_n),
        .flush   (flush),
        .want    (want),
        .word_if (word_if),
        .avail   (ser_avail),
        .bit_o   (ser_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        cen_d   = 1'b0;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
                    state_d = ST_PREAMBLE;
`else
                    state_d = ST_LOAD;
`endif
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
            ST_PREAMBLE: begin
                head_d = CCFF_MARKER[cnt_q[2:0]];
                cen_d  = 1'b1;
                cnt_d  = cnt_q + 32'd1;
                if (cnt_q[2:0] == 3'd7) state_d = ST_LOAD;
            end
`endif
            ST_LOAD: begin
                if (cnt_q == TOTAL) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (ser_avail) begin
                    head_d = ser_bit;
                    cen_d  = 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            cen_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            cen_q   <= cen_d;
            done_q  <= done_d;
        end
    end

    assign ccff_head     = head_q;
    assign config_enable = cen_q;
    assign done          = done_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_PREAMBLE);

`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    // Marker bit 0 reaches the tail exactly CHAIN_LEN shifts after it entered the head
    logic        err_q, err_d;
    logic [31:0] chk_n;
    logic [2:0]  chk_sel;

    always_comb begin
        err_d   = err_q;
        chk_n   = cnt_q - 32'd1;
        chk_sel = 3'(chk_n - 32'(CHAIN_LEN));
        if (flush) begin
            err_d = 1'b0;
        end else if (cen_q && (chk_n >= 32'(CHAIN_LEN)) && (chk_n < 32'(CHAIN_LEN + 8))
                     && (ccff_tail != CCFF_MARKER[chk_sel])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) err_q <= 1'b0;
        else               err_q <= err_d;
    end

    assign chain_err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign chain_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader (CHAIN_LEN=20, WORD_W=8) with a behavioural chain model.
module tb_ccff_chain_loader;
    localparam int L  = 20;
    localparam int WW = 8;
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int PRE = 8 * CHK;

    logic prog_clock = 1'b0;
    logic prog_reset_n = 1'b1;
    logic start = 1'b0;
    logic ccff_tail, ccff_head, config_enable, busy, done, chain_err;

    ccff_chain_loader_if #(.WORD_W(WW)) wif ();

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(WW)) dut (
        .prog_clock    (prog_clock),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .ccff_tail     (ccff_tail),
        .word_if       (wif.slave),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .chain_err     (chain_err)
    );

    always #5 prog_clock = ~prog_clock;

    // Behavioural CCFF chain: cell 0 takes the head, tail is cell cells-1
    logic [31:0] chain = '0;
    int          cells = 20;
    always @(posedge prog_clock) if (config_enable) chain <= {chain[30:0], ccff_head};
    assign ccff_tail = chain[cells-1];

    typedef struct {
        logic [7:0]  w0, w1, w2;
        int          stall_n;   // ready cycles withheld before word 1
        int          cells;
        bit          restart;
        logic [19:0] exp_bits;  // bit i = i-th data bit on ccff_head
        int          exp_done;
        int          exp_gap;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];
    int   n_vec = 0, n_bad = 0;
    int   accepted;
    bit   run_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_words(input vec_t v);
        logic [7:0] w[3];
        int idx = 0, stall = 0, guard = 0;
        w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
        accepted = 0;
        wif.word_data  = w[0];
        wif.word_valid = 1'b1;
        while (run_on && guard < 400) begin
            @(negedge prog_clock);
            guard++;
            if (wif.word_valid && wif.word_ready) begin
                accepted++;
                @(posedge prog_clock); #1;
                idx++;
                if (idx < 3) begin
                    wif.word_data = w[idx];
                    if (idx == 1 && v.stall_n > 0) begin
                        stall = v.stall_n;
                        wif.word_valid = 1'b0;
                    end
                end else begin
                    wif.word_data = 8'hEE;  // surplus word that must never be taken
                end
            end else if (!wif.word_valid && wif.word_ready && stall > 0) begin
                stall--;
                if (stall == 0) begin
                    @(posedge prog_clock); #1;
                    wif.word_valid = 1'b1;
                end
            end
        end
        wif.word_valid = 1'b0;
    endtask

    task automatic monitor(input vec_t v);
        logic [63:0] stream = '0;
        logic [31:0] act_c = '0, exp_c = '0;
        int ns = 0, j = 0, done_at = -1, first_en = -1, gap = 0, rises = 0;
        logic pd = 1'b0;
        @(negedge prog_clock);
        start = 1'b1;
        while (j < 300 && !(done_at >= 0 && j >= done_at + 3)) begin
            @(negedge prog_clock);
            j++;
            if (j == 1) begin
                start = 1'b0;
                chk("busy_after_start", {31'd0, busy}, 32'd1);
            end
            if (v.restart && j == 5) start = 1'b1;
            if (v.restart && j == 6) start = 1'b0;
            if (config_enable) begin
                if (first_en < 0) first_en = j;
                if (ns < 64) stream[ns] = ccff_head;
                ns++;
            end else if (first_en >= 0 && !done) begin
                gap++;
            end
            if (done && !pd) rises++;
            if (done && done_at < 0) done_at = j;
            pd = done;
        end
        if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("done_cycle", done_at, v.exp_done);
        chk("first_shift_cycle", first_en, 32'd2);
        chk("enabled_cycles", ns, L + PRE);
        chk("starve_gap", gap, v.exp_gap);
        chk("done_rises", rises, 32'd1);
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("done_level", {31'd0, done}, 32'd1);
        chk("chain_err", {31'd0, chain_err}, {31'd0, v.exp_err});
        chk("head_data_bits", 32'(stream[PRE +: 20]), 32'(v.exp_bits));
`ifdef CCFF_LOADER_CHAIN_CHECK_EN
        chk("head_marker", 32'(stream[7:0]), 32'h0000_00A5);
`endif
        for (int c = 0; c < v.cells && c < L; c++) begin
            act_c[c] = chain[c];
            exp_c[c] = v.exp_bits[L-1-c];
        end
        chk("chain_contents", act_c, exp_c);
        run_on = 1'b0;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        v = vecs[vi];
        cells  = v.cells;
        run_on = 1'b1;
        fork
            drive_words(v);
            monitor(v);
        join
        chk("words_accepted", accepted, 32'd3);
    endtask

    initial begin
        int guard;
        vecs[0] = '{8'h3C, 8'h81, 8'hF7, 0, 20, 1'b0, 20'h7813C, 22 + PRE, 0, 1'b0};
        vecs[1] = '{8'h3C, 8'h81, 8'hF7, 4, 20, 1'b0, 20'h7813C, 25 + PRE, 3, 1'b0};
        vecs[2] = '{8'h3C, 8'h81, 8'hF7, 0, 19, 1'b0, 20'h7813C, 22 + PRE, 0, CHK[0]};
        vecs[3] = '{8'hFF, 8'h00, 8'h5A, 0, 20, 1'b1, 20'hA00FF, 22 + PRE, 0, 1'b0};
        vecs[4] = '{8'h01, 8'h80, 8'hA0, 4, 20, 1'b0, 20'h08001, 25 + PRE, 3, 1'b0};

        wif.word_data  = 8'h00;
        wif.word_valid = 1'b0;
        #1 prog_reset_n = 1'b0;
        #1 chk("reset_outputs", {26'd0, ccff_head, config_enable, wif.word_ready, busy, done, chain_err}, 32'd0);
        repeat (2) @(negedge prog_clock);
        prog_reset_n = 1'b1;

        // Words offered in IDLE must not be accepted
        wif.word_data  = 8'h55;
        wif.word_valid = 1'b1;
        repeat (3) @(negedge prog_clock);
        chk("idle_ready_low", {31'd0, wif.word_ready}, 32'd0);
        chk("idle_no_enable", {31'd0, config_enable}, 32'd0);
        wif.word_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset during the 10th data shift, then a clean reload
        cells          = 20;
        wif.word_data  = 8'h3C;
        wif.word_valid = 1'b1;
        @(negedge prog_clock);
        start = 1'b1;
        @(negedge prog_clock);
        start = 1'b0;
        guard = 0;
        while (guard < 100) begin
            if (config_enable && dut.cnt_q == 32'(PRE + 10)) break;
            @(negedge prog_clock);
            guard++;
        end
        chk("reach_shift10", {31'd0, guard < 100}, 32'd1);
        chk("head_or_enable_active", {31'd0, config_enable}, 32'd1);
        prog_reset_n = 1'b0;
        #1 chk("reset_mid_outputs", {26'd0, ccff_head, config_enable, wif.word_ready, busy, done, chain_err}, 32'd0);
        wif.word_valid = 1'b0;
        @(negedge prog_clock);
        prog_reset_n = 1'b1;
        @(negedge prog_clock);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader that drives the head of a configuration flip-flop (CCFF) chain, for example the chain formed by IO flip-flop mode memories. It accepts configuration words over a valid/ready stream and serializes them, LSB first, onto `ccff_head`. It gates the chain with `config_enable` so that exactly `CHAIN_LEN` bits land in the chain. The block sits in the programming domain between the bitstream source and the fabric's chain head; the chain tail is looped back for an optional integrity check.

## Interface
- `CHAIN_LEN`, default 64: number of CCFF cells in the chain (≥ 1).
- `WORD_W`, default 8: input word width (≥ 1).
- `prog_clock` input 1: programming clock. The loader and the chain both run on it.
- `prog_reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a load. Sampled only in IDLE.
- `word_data` input WORD_W: configuration word. Bit 0 is shifted first.
- `word_valid` input 1: `word_data` is valid.
- `word_ready` output 1: loader accepts a word this cycle.
- `ccff_tail` input 1: last cell of the chain, looped back.
- `ccff_head` output 1: serial bit into the first chain cell. Registered.
- `config_enable` output 1: the chain shifts on a `prog_clock` edge only while this is high. Registered.
- `busy` output 1: high from the cycle after an accepted `start` until `done` rises.
- `done` output 1: load complete. Level, cleared by the next accepted `start`.
- `chain_err` output 1: integrity check failed. Level, cleared by the next accepted `start`. Tied to 0 when the check is compiled out.

## Operation
- State machine:
  - IDLE: `start` moves to PREAMBLE if the check is compiled in, else to LOAD. Both `done` and `chain_err` clear.
  - PREAMBLE: shifts the 8-bit marker 8'hA5, LSB first. Needs no input words. Then moves to LOAD.
  - LOAD: shifts `CHAIN_LEN` data bits. Then moves to DONE.
  - DONE: sets `done`, drops `busy`, returns to IDLE in the next cycle.
- Word fetch:
  - Internal WORD_W shift buffer plus bit index.
  - `word_ready` is high in LOAD when the buffer is empty, or when its last bit is being shifted this cycle. This allows back-to-back words with no bubble.
  - A word transfers on `word_valid && word_ready`.
- Words and bit ordering:
  - Total words per load = ceil(CHAIN_LEN / WORD_W).
  - Upper unused bits of the final word are discarded and never shifted.
  - No word is requested after the final word.
- Shift cycle:
  - Each cycle with data available, the next cycle has `config_enable`=1 and `ccff_head`=bit; a 32-bit shift counter increments.
- Starvation: if the buffer is empty and `word_valid`=0, the next cycle has `config_enable`=0 and `ccff_head` holds its last value. The chain does not shift and the counter does not advance.
- Bit placement: the first data bit shifted ends in the last cell (`ccff_tail`); the last data bit ends in the first cell.
- `start` while busy is ignored.
- Words offered outside LOAD are not accepted.
- Reset mid-load:
  - All outputs go to reset values immediately and the FSM returns to IDLE.
  - Chain contents are undefined; software must reload.

## Timing
- Reset values: `ccff_head`=0, `config_enable`=0, `word_ready`=0, `busy`=0, `done`=0, `chain_err`=0.
- `start` at edge k: `busy`=1 after edge k. The first shift cycle (`config_enable`=1) follows edge k+1.
- Shift count: with no starvation, there are exactly `CHAIN_LEN` (+8 with check) consecutive cycles of `config_enable`=1.
- Completion: `config_enable` falls and `done` rises on the same edge after the final shift; `busy` falls on that edge.
- Minimum load time from `start` to `done`: CHAIN_LEN+2 cycles, or CHAIN_LEN+10 with the check.

## Configuration
- Macro: `CCFF_LOADER_CHAIN_CHECK_EN`.
- Defined:
  - PREAMBLE state present.
  - During LOAD shift cycles CHAIN_LEN..CHAIN_LEN+7 (0-based count of all shifts including preamble), `ccff_tail` is compared against marker bit (n−CHAIN_LEN). This catches a broken chain or a wrong length.
  - Any mismatch sets `chain_err`, which persists through DONE.
- Undefined: no PREAMBLE state, `chain_err` is tied to 0, and no comparator logic is generated.

## Structure
- The shared package `ccff_loader_pkg` holds:
  - the FSM state enum (IDLE, PREAMBLE, LOAD, DONE);
  - the marker constant `CCFF_MARKER` = 8'hA5 and the marker length constant 8;
  - a function computing words per load from CHAIN_LEN and WORD_W.
- One natural sub-module, `ccff_word_serializer`: the WORD_W buffer, bit index, `word_ready` generation, and the empty flag. The top level holds the FSM, the shift counter, and the checker.

## Test plan
- CHAIN_LEN=20, WORD_W=8, words 8'h3C, 8'h81, 8'hF7 with valid always high → 3 words accepted, 20 enabled cycles, and `ccff_head` sequence 0,0,1,1,1,1,0,0,1,0,0,0,0,0,0,1,1,1,1,0. Bits 7:4 of 8'hF7 are never shifted; `done` rises at cycle 22 after `start`.
- Same words with `word_valid` low for 3 cycles before word 2 → `config_enable` low for exactly 3 cycles, same bit sequence, `done` 3 cycles later.
- Behavioural 20-cell chain model, check compiled in → 28 shifts, `chain_err`=0, and the model ends holding the 20 data bits in order.
- Chain model shortened to 19 cells, check compiled in → `chain_err`=1 with `done`=1.
- `prog_reset_n` asserted at shift 10 → all outputs 0 immediately. A new `start` after release yields a full correct load.
- `start` pulsed while `busy` → ignored; exactly one `done` and CHAIN_LEN enabled shifts.
